// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for a single synchronous FIFO.
// The granted producer may push up to BURST words before the grant rotates.
module fifo_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int BURST   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_wr_en,
  output logic [WIDTH-1:0]           fifo_data,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  beat_cnt;

  logic              arb_hit;
  logic [ID_W-1:0]   arb_id;
  logic [WIDTH-1:0]  req_word [NUM_REQ];
  logic              gnt_valid;
  logic              xfer;
  logic              burst_done;
  logic              release_gnt;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == LAST_ID) ? '0 : id + ID_W'(1);
  endfunction

  // Arbitration: first valid producer at or after rr_ptr, wrapping.
  always_comb begin
    arb_hit = 1'b0;
    arb_id  = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[ID_W'((int'(rr_ptr) + k) % NUM_REQ)]) begin
        arb_hit = 1'b1;
        arb_id  = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  // Grant datapath: purely combinational so a granted word moves in the same cycle.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_word[g] = req_data[g*WIDTH +: WIDTH];
  end

  assign busy        = (state == GRANT);
  assign gnt_valid   = req_valid[grant_id];
  assign xfer        = busy && gnt_valid && !fifo_full;
  assign burst_done  = xfer && (beat_cnt == LAST_BEAT);
  assign release_gnt = busy && (burst_done || !gnt_valid);

  always_comb begin
    req_ready = '0;
    if (busy && !fifo_full) req_ready[grant_id] = 1'b1;
  end

  assign fifo_wr_en = xfer;
  assign fifo_data  = xfer ? req_word[grant_id] : '0;

  // Control FSM: a full FIFO only stalls the grant, it never revokes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_hit) begin
            grant_id <= arb_id;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (xfer) beat_cnt <= beat_cnt + CNT_W'(1);
          if (release_gnt) begin
            state  <= IDLE;
            rr_ptr <= next_id(grant_id);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(fifo_wr_en && fifo_full));
  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed vectors feed an expected-write queue,
// a negedge monitor pops and compares every FIFO write.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int BURST   = 4;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full;
  logic                     fifo_wr_en;
  logic [WIDTH-1:0]         fifo_data;
  logic [1:0]               grant_id;
  logic                     busy;

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_data(fifo_data), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Expected writes: {grant_id, data}; data = {producer, sequence}
  logic [9:0]         gexp [$];
  logic [7:0]         exp_p [NUM_REQ][$];
  bit                 rand_mode = 1'b0;
  int                 cnt [NUM_REQ];
  logic [5:0]         seq [NUM_REQ];
  logic [NUM_REQ-1:0] acc;
  logic [NUM_REQ-1:0] rvalid;
  logic [63:0]        hist;
  logic [9:0]         mon_e;
  logic [1:0]         mon_id;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: actual=write required=no_write", name);
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_data[i*WIDTH +: WIDTH] = {2'(i), seq[i]};
      req_valid[i] = rand_mode ? rvalid[i] : (cnt[i] > 0);
    end
  endtask

  task automatic step();
    @(negedge clk);
    acc  = req_valid & req_ready;
    hist = {hist[62:0], fifo_wr_en};
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) begin
        seq[i] = seq[i] + 6'd1;
        if (rand_mode) exp_p[i].push_back({2'(i), seq[i]});
        else cnt[i] = cnt[i] - 1;
      end
    end
    if (rand_mode) begin
      for (int i = 0; i < NUM_REQ; i++) rvalid[i] = ($urandom_range(0, 9) < 7);
      fifo_full = ($urandom_range(0, 9) < 3);
    end
    drive();
  endtask

  task automatic do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt[i] = 0;
      seq[i] = '0;
    end
    rvalid    = '0;
    fifo_full = 1'b0;
    drive();
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    hist = '0;
  endtask

  // Monitor: checks every cycle and pops one expectation per FIFO write.
  always @(negedge clk) begin
    if (rst) begin
      chk("wr_en_in_reset", fifo_wr_en, 0);
    end else begin
      chk("ready_onehot0", $onehot0(req_ready), 1);
      chk("no_write_when_full", fifo_wr_en & fifo_full, 0);
      chk("wr_en_vs_handshake", fifo_wr_en, |(req_valid & req_ready));
      if (fifo_wr_en) begin
        if (!rand_mode) begin
          if (gexp.size() == 0) fail_now("unexpected_write");
          else begin
            mon_e = gexp.pop_front();
            chk("wr_data", fifo_data, mon_e[7:0]);
            chk("wr_grant_id", grant_id, mon_e[9:8]);
          end
        end else begin
          mon_id = fifo_data[7:6];
          chk("rand_grant_id", grant_id, mon_id);
          if (exp_p[mon_id].size() == 0) fail_now("rand_unexpected_write");
          else chk("rand_order", fifo_data, exp_p[mon_id].pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    rvalid    = '0;
    hist      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt[i] = 0;
      seq[i] = '0;
    end
    #2 rst = 1'b1;
    #1;
    chk("reset_wr_en", fifo_wr_en, 0);
    chk("reset_ready", req_ready, 0);
    chk("reset_data", fifo_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_grant_id", grant_id, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Single producer: bursts of 4,4,2 separated by one idle cycle
    cnt[2] = 10;
    for (int n = 0; n < 10; n++) gexp.push_back({2'd2, 2'd2, 6'(n)});
    hist = '0;
    drive();
    repeat (14) step();
    chk("single_pattern", hist[13:0], 14'b01111011110110);
    chk("single_drained", gexp.size(), 0);
    do_reset();

    // Round robin: all four producers, 8 words each
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NUM_REQ; p++)
        for (int n = 0; n < 4; n++) gexp.push_back({2'(p), 2'(p), 6'(r*4 + n)});
    for (int i = 0; i < NUM_REQ; i++) cnt[i] = 8;
    drive();
    repeat (40) step();
    chk("rr_pattern", hist[39:0], {8{5'b01111}});
    chk("rr_drained", gexp.size(), 0);
    chk("rr_idle_after", busy, 0);
    do_reset();

    // Full stall after the 2nd word of a burst
    cnt[0] = 4;
    for (int n = 0; n < 4; n++) gexp.push_back({2'd0, 2'd0, 6'(n)});
    drive();
    repeat (3) step();
    fifo_full = 1'b1;
    repeat (5) begin
      #1;
      chk("stall_ready", req_ready, 0);
      chk("stall_busy", busy, 1);
      chk("stall_grant", grant_id, 0);
      chk("stall_beat_cnt", dut.beat_cnt, 2);
      step();
    end
    fifo_full = 1'b0;
    repeat (3) step();
    chk("stall_pattern", hist[10:0], 11'b01100000110);
    chk("stall_drained", gexp.size(), 0);
    chk("stall_released", busy, 0);
    do_reset();

    // Early release: producer 1 stops after one word, producer 3 waiting
    cnt[1] = 1;
    cnt[3] = 2;
    gexp.push_back({2'd1, 2'd1, 6'd0});
    gexp.push_back({2'd3, 2'd3, 6'd0});
    gexp.push_back({2'd3, 2'd3, 6'd1});
    drive();
    step();
    step();
    #1;
    chk("early_busy_held", busy, 1);
    chk("early_grant_1", grant_id, 1);
    chk("early_no_write", fifo_wr_en, 0);
    step();
    #1;
    chk("early_idle", busy, 0);
    chk("early_rr_ptr", dut.rr_ptr, 2);
    step();
    #1;
    chk("early_grant_3", grant_id, 3);
    repeat (3) step();
    chk("early_pattern", hist[6:0], 7'b0100110);
    chk("early_drained", gexp.size(), 0);
    do_reset();

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < NUM_REQ; i++) cnt[i] = 8;
    gexp.push_back({2'd0, 2'd0, 6'd0});
    gexp.push_back({2'd0, 2'd0, 6'd1});
    drive();
    repeat (3) step();
    #1;
    chk("pre_reset_write", fifo_wr_en, 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_wr_en", fifo_wr_en, 0);
    chk("midrst_ready", req_ready, 0);
    chk("midrst_data", fifo_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_grant_id", grant_id, 0);
    chk("midrst_rr_ptr", dut.rr_ptr, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt[i] = 0;
      seq[i] = '0;
    end
    drive();
    rst = 1'b0;
    chk("midrst_drained", gexp.size(), 0);
    do_reset();

    // Random valid/full traffic, per-producer ordering
    rand_mode = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      exp_p[i].push_back({2'(i), 6'd0});
      rvalid[i] = ($urandom_range(0, 9) < 7);
    end
    drive();
    repeat (10000) step();
    for (int i = 0; i < NUM_REQ; i++) chk("rand_pending", exp_p[i].size(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
